// File: rtl/div_seq_pkg.sv
// Shared state codes and control constants for the EX-stage divide sequencer.
// Imported by div_seq and by the EX stage that drives it.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
// Purely combinational; the sequencer applies it once per cycle.
module div_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rem_i,
    input  logic          dvd_msb_i,
    input  logic [DW-1:0] dvs_i,
    output logic [DW-1:0] rem_o,
    output logic          q_bit_o
);

    logic [DW:0] trial;
    logic [DW:0] diff;

    // trial < 2*divisor always, so DW+1 bits give a correct sign bit on the difference
    assign trial   = {rem_i, dvd_msb_i};
    assign diff    = trial - {1'b0, dvs_i};
    assign q_bit_o = ~diff[DW];
    assign rem_o   = q_bit_o ? diff[DW-1:0] : trial[DW-1:0];

endmodule

// File: rtl/div_seq.sv
// Radix-2 restoring divide sequencer (DIV/DIVU) for EX; result = {remainder, quotient}.
// Optional macro DIV_EARLY_EXIT_EN: finish immediately when |dividend| < |divisor|.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            start_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    dvd_q, dvd_d;
    logic [DW-1:0]    dvs_q, dvs_d;
    logic             sign1_q, sign1_d;
    logic             sign2_q, sign2_d;
    logic [2*DW-1:0]  result_q, result_d;
    logic             ready_q, ready_d;

    logic [DW-1:0]    op1_abs, op2_abs;
    logic             op1_neg, op2_neg;
    logic [DW-1:0]    step_rem;
    logic             step_qbit;
    logic [DW-1:0]    quo_fix, rem_fix;

    assign op1_neg = signed_div_i & opdata1_i[DW-1];
    assign op2_neg = signed_div_i & opdata2_i[DW-1];
    assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

    div_step #(.DW(DW)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[DW-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // Dividend register shifts left, collecting quotient bits from the bottom
    assign quo_fix = (sign1_q ^ sign2_q) ? -dvd_q : dvd_q;
    assign rem_fix = sign1_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    dvd_d   = op1_abs;
                    dvs_d   = op2_abs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    sign1_d = op1_neg;
                    sign2_d = op2_neg;
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (op1_abs < op2_abs) begin
                        state_d  = DivEnd;
                        ready_d  = DivResultReady;
                        result_d = {opdata1_i, {DW{1'b0}}};
                    end
`endif
                    else begin
                        state_d = DivOn;
                    end
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = '0;
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (cnt_q != CNT_W'(DW)) begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[DW-2:0], step_qbit};
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = DivEnd;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: state_d = DivFree;
        endcase

        // A flush never lets a partial or stale result escape
        if (annul_i && state_q != DivFree) begin
            state_d  = DivFree;
            result_d = '0;
            ready_d  = DivResultNotReady;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule
